// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the hardwired control unit: opcodes, state and class codes,
// and the packed strobe bundle produced by the output decoder.
package control_sequencer_pkg;

    localparam int OPW = 5;

    localparam logic [OPW-1:0] OP_LD   = 5'b00000;
    localparam logic [OPW-1:0] OP_LDI  = 5'b00001;
    localparam logic [OPW-1:0] OP_ST   = 5'b00010;
    localparam logic [OPW-1:0] OP_ADD  = 5'b00011;
    localparam logic [OPW-1:0] OP_SUB  = 5'b00100;
    localparam logic [OPW-1:0] OP_AND  = 5'b00101;
    localparam logic [OPW-1:0] OP_OR   = 5'b00110;
    localparam logic [OPW-1:0] OP_SHR  = 5'b00111;
    localparam logic [OPW-1:0] OP_SHL  = 5'b01000;
    localparam logic [OPW-1:0] OP_ROR  = 5'b01001;
    localparam logic [OPW-1:0] OP_ROL  = 5'b01010;
    localparam logic [OPW-1:0] OP_ADDI = 5'b01011;
    localparam logic [OPW-1:0] OP_ANDI = 5'b01100;
    localparam logic [OPW-1:0] OP_ORI  = 5'b01101;
    localparam logic [OPW-1:0] OP_MUL  = 5'b01110;
    localparam logic [OPW-1:0] OP_DIV  = 5'b01111;
    localparam logic [OPW-1:0] OP_NEG  = 5'b10000;
    localparam logic [OPW-1:0] OP_NOT  = 5'b10001;
    localparam logic [OPW-1:0] OP_BR   = 5'b10010;
    localparam logic [OPW-1:0] OP_JR   = 5'b10011;
    localparam logic [OPW-1:0] OP_JAL  = 5'b10100;
    localparam logic [OPW-1:0] OP_IN   = 5'b10101;
    localparam logic [OPW-1:0] OP_OUT  = 5'b10110;
    localparam logic [OPW-1:0] OP_MFHI = 5'b10111;
    localparam logic [OPW-1:0] OP_MFLO = 5'b11000;
    localparam logic [OPW-1:0] OP_NOP  = 5'b11001;
    localparam logic [OPW-1:0] OP_HALT = 5'b11010;

    // Address and branch-target arithmetic always use the ADD function code.
    localparam logic [OPW-1:0] ALU_ADD = OP_ADD;

    typedef enum logic [3:0] {
        S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    typedef enum logic [3:0] {
        CL_RR, CL_IMM, CL_UN, CL_MD, CL_LD, CL_LDI, CL_ST, CL_BR,
        CL_JR, CL_JAL, CL_IN, CL_OUT, CL_MFHI, CL_MFLO, CL_NOP, CL_HALT
    } op_class_t;

    typedef struct packed {
        logic pc_out, zhigh_out, zlow_out, mdr_out, hi_out, lo_out, inport_out, c_out, ba_out;
        logic mar_in, z_in, pc_in, mdr_in, ir_in, y_in, hi_in, lo_in, outport_in, con_in, r_in;
        logic gra, grb, grc, r_out, inc_pc, read, write;
    } strobes_t;

endpackage

// File: rtl/control_sequencer_if.sv
// Datapath-facing control bundle: instruction/condition inputs to the sequencer and
// every strobe it drives back into the datapath.
interface control_sequencer_if;
    import control_sequencer_pkg::*;

    logic [31:0]    IR;
    logic           CON_FF;
    logic           Stop;
    logic           PCout, Zhighout, Zlowout, MDRout, HIout, LOout, InPortout, Cout, BAout;
    logic           MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, OutPortin, CONin, Rin;
    logic           Gra, Grb, Grc, Rout, IncPC, Read, Write;
    logic [OPW-1:0] alu_op;
    logic           Run;

    modport master (
        input  IR, CON_FF, Stop,
        output PCout, Zhighout, Zlowout, MDRout, HIout, LOout, InPortout, Cout, BAout,
        output MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, OutPortin, CONin, Rin,
        output Gra, Grb, Grc, Rout, IncPC, Read, Write, alu_op, Run
    );

    modport slave (
        output IR, CON_FF, Stop,
        input  PCout, Zhighout, Zlowout, MDRout, HIout, LOout, InPortout, Cout, BAout,
        input  MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin, OutPortin, CONin, Rin,
        input  Gra, Grb, Grc, Rout, IncPC, Read, Write, alu_op, Run
    );
endinterface

// File: rtl/ctrl_class_decode.sv
// Combinational opcode -> instruction class map; unlisted opcodes behave as nop.
module ctrl_class_decode
    import control_sequencer_pkg::*;
(
    input  logic [OPW-1:0] opcode,
    output op_class_t      op_class
);
    always_comb begin
        op_class = CL_NOP;
        case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_SHR, OP_SHL, OP_ROR, OP_ROL: op_class = CL_RR;
            OP_ADDI, OP_ANDI, OP_ORI:       op_class = CL_IMM;
            OP_NEG, OP_NOT:                 op_class = CL_UN;
            OP_MUL, OP_DIV:                 op_class = CL_MD;
            OP_LD:                          op_class = CL_LD;
            OP_LDI:                         op_class = CL_LDI;
            OP_ST:                          op_class = CL_ST;
            OP_BR:                          op_class = CL_BR;
            OP_JR:                          op_class = CL_JR;
            OP_JAL:                         op_class = CL_JAL;
            OP_IN:                          op_class = CL_IN;
            OP_OUT:                         op_class = CL_OUT;
            OP_MFHI:                        op_class = CL_MFHI;
            OP_MFLO:                        op_class = CL_MFLO;
            OP_HALT:                        op_class = CL_HALT;
            default:                        op_class = CL_NOP;
        endcase
    end
endmodule

// File: rtl/control_sequencer.sv
// Hardwired control sequencer: fetch T0-T2, class-dependent execute T3-T7,
// Moore strobes decoded from the current step and latched opcode.
module control_sequencer
    import control_sequencer_pkg::*;
(
    input  logic                 Clock,
    input  logic                 Clear,
    control_sequencer_if.master  bus
);
    state_t         state_reg, state_next;
    logic [OPW-1:0] op_reg;
    logic [OPW-1:0] dec_opcode;
    op_class_t      op_class;
    strobes_t       strb;
    logic [OPW-1:0] alu_op_next;
    logic           last_step;
    logic [26:0]    unused_ir;

    assign unused_ir = bus.IR[26:0];

    // During T2 the class comes straight from IR so nop/halt can exit fetch;
    // afterwards only the latched opcode steers the sequence.
    assign dec_opcode = (state_reg == S_T2) ? bus.IR[31:27] : op_reg;

    ctrl_class_decode u_class_decode (
        .opcode   (dec_opcode),
        .op_class (op_class)
    );

    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            state_reg <= S_RESET;
            op_reg    <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == S_T2)
                op_reg <= bus.IR[31:27];
        end
    end

    always_comb begin
        strb        = '0;
        alu_op_next = '0;
        last_step   = 1'b0;
        case (state_reg)
            S_T0: begin strb.pc_out = 1'b1; strb.mar_in = 1'b1; strb.inc_pc = 1'b1; strb.z_in = 1'b1; end
            S_T1: begin strb.zlow_out = 1'b1; strb.pc_in = 1'b1; strb.read = 1'b1; strb.mdr_in = 1'b1; end
            S_T2: begin strb.mdr_out = 1'b1; strb.ir_in = 1'b1; end
            S_T3: begin
                case (op_class)
                    CL_RR, CL_IMM: begin strb.grb = 1'b1; strb.r_out = 1'b1; strb.y_in = 1'b1; end
                    CL_UN: begin strb.grb = 1'b1; strb.r_out = 1'b1; strb.z_in = 1'b1; alu_op_next = op_reg; end
                    CL_MD: begin strb.gra = 1'b1; strb.r_out = 1'b1; strb.y_in = 1'b1; end
                    CL_LD, CL_LDI, CL_ST: begin strb.grb = 1'b1; strb.ba_out = 1'b1; strb.y_in = 1'b1; end
                    CL_BR: begin strb.gra = 1'b1; strb.r_out = 1'b1; strb.con_in = 1'b1; end
                    CL_JR: begin strb.gra = 1'b1; strb.r_out = 1'b1; strb.pc_in = 1'b1; last_step = 1'b1; end
                    CL_JAL: begin strb.pc_out = 1'b1; strb.grb = 1'b1; strb.r_in = 1'b1; end
                    CL_IN: begin strb.inport_out = 1'b1; strb.gra = 1'b1; strb.r_in = 1'b1; last_step = 1'b1; end
                    CL_OUT: begin strb.gra = 1'b1; strb.r_out = 1'b1; strb.outport_in = 1'b1; last_step = 1'b1; end
                    CL_MFHI: begin strb.hi_out = 1'b1; strb.gra = 1'b1; strb.r_in = 1'b1; last_step = 1'b1; end
                    CL_MFLO: begin strb.lo_out = 1'b1; strb.gra = 1'b1; strb.r_in = 1'b1; last_step = 1'b1; end
                    default: last_step = 1'b1;
                endcase
            end
            S_T4: begin
                case (op_class)
                    CL_RR: begin strb.grc = 1'b1; strb.r_out = 1'b1; strb.z_in = 1'b1; alu_op_next = op_reg; end
                    CL_IMM: begin strb.c_out = 1'b1; strb.z_in = 1'b1; alu_op_next = op_reg; end
                    CL_UN: begin strb.zlow_out = 1'b1; strb.gra = 1'b1; strb.r_in = 1'b1; last_step = 1'b1; end
                    CL_MD: begin strb.grb = 1'b1; strb.r_out = 1'b1; strb.z_in = 1'b1; alu_op_next = op_reg; end
                    CL_LD, CL_LDI, CL_ST: begin strb.c_out = 1'b1; strb.z_in = 1'b1; alu_op_next = ALU_ADD; end
                    CL_BR: begin strb.pc_out = 1'b1; strb.y_in = 1'b1; end
                    CL_JAL: begin strb.gra = 1'b1; strb.r_out = 1'b1; strb.pc_in = 1'b1; last_step = 1'b1; end
                    default: last_step = 1'b1;
                endcase
            end
            S_T5: begin
                case (op_class)
                    CL_RR, CL_IMM, CL_LDI: begin
                        strb.zlow_out = 1'b1; strb.gra = 1'b1; strb.r_in = 1'b1; last_step = 1'b1;
                    end
                    CL_MD: begin strb.zlow_out = 1'b1; strb.lo_in = 1'b1; end
                    CL_LD, CL_ST: begin strb.zlow_out = 1'b1; strb.mar_in = 1'b1; end
                    CL_BR: begin strb.c_out = 1'b1; strb.z_in = 1'b1; alu_op_next = ALU_ADD; end
                    default: last_step = 1'b1;
                endcase
            end
            S_T6: begin
                case (op_class)
                    CL_MD: begin strb.zhigh_out = 1'b1; strb.hi_in = 1'b1; last_step = 1'b1; end
                    CL_LD: begin strb.read = 1'b1; strb.mdr_in = 1'b1; end
                    CL_ST: begin strb.gra = 1'b1; strb.r_out = 1'b1; strb.mdr_in = 1'b1; end
                    // Not-taken branches still spend this step so branch latency is fixed.
                    CL_BR: begin
                        strb.zlow_out = bus.CON_FF; strb.pc_in = bus.CON_FF; last_step = 1'b1;
                    end
                    default: last_step = 1'b1;
                endcase
            end
            S_T7: begin
                case (op_class)
                    CL_LD: begin strb.mdr_out = 1'b1; strb.gra = 1'b1; strb.r_in = 1'b1; last_step = 1'b1; end
                    CL_ST: begin strb.write = 1'b1; last_step = 1'b1; end
                    default: last_step = 1'b1;
                endcase
            end
            default: ;
        endcase
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_RESET: state_next = S_T0;
            S_T0:    state_next = S_T1;
            S_T1:    state_next = S_T2;
            S_T2: begin
                if (op_class == CL_HALT)     state_next = S_HALT;
                else if (op_class == CL_NOP) state_next = bus.Stop ? S_HALT : S_T0;
                else                         state_next = S_T3;
            end
            S_T3, S_T4, S_T5, S_T6, S_T7: begin
                if (last_step)               state_next = bus.Stop ? S_HALT : S_T0;
                else                         state_next = state_t'(state_reg + 4'd1);
            end
            S_HALT:  state_next = S_HALT;
            default: state_next = S_RESET;
        endcase
    end

    assign bus.PCout     = strb.pc_out;
    assign bus.Zhighout  = strb.zhigh_out;
    assign bus.Zlowout   = strb.zlow_out;
    assign bus.MDRout    = strb.mdr_out;
    assign bus.HIout     = strb.hi_out;
    assign bus.LOout     = strb.lo_out;
    assign bus.InPortout = strb.inport_out;
    assign bus.Cout      = strb.c_out;
    assign bus.BAout     = strb.ba_out;
    assign bus.MARin     = strb.mar_in;
    assign bus.Zin       = strb.z_in;
    assign bus.PCin      = strb.pc_in;
    assign bus.MDRin     = strb.mdr_in;
    assign bus.IRin      = strb.ir_in;
    assign bus.Yin       = strb.y_in;
    assign bus.HIin      = strb.hi_in;
    assign bus.LOin      = strb.lo_in;
    assign bus.OutPortin = strb.outport_in;
    assign bus.CONin     = strb.con_in;
    assign bus.Rin       = strb.r_in;
    assign bus.Gra       = strb.gra;
    assign bus.Grb       = strb.grb;
    assign bus.Grc       = strb.grc;
    assign bus.Rout      = strb.r_out;
    assign bus.IncPC     = strb.inc_pc;
    assign bus.Read      = strb.read;
    assign bus.Write     = strb.write;
    assign bus.alu_op    = alu_op_next;
    assign bus.Run       = (state_reg != S_RESET) && (state_reg != S_HALT);

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench: each step pushes the expected strobe vector to a scoreboard,
// advances one clock and pops/compares against the observed outputs.
module tb_control_sequencer;
    logic Clock = 1'b0;
    logic Clear = 1'b0;
    control_sequencer_if bus ();

    control_sequencer dut (.Clock(Clock), .Clear(Clear), .bus(bus));

    always #5 Clock = ~Clock;

    // Vector layout: [32] Run, [31:27] alu_op, [26:0] strobes.
    localparam logic [32:0] PCOUT = 33'h1 << 0,  ZHIGH = 33'h1 << 1,  ZLOW = 33'h1 << 2;
    localparam logic [32:0] MDROUT = 33'h1 << 3, HIOUT = 33'h1 << 4,  LOOUT = 33'h1 << 5;
    localparam logic [32:0] INPOUT = 33'h1 << 6, COUT = 33'h1 << 7,   BAOUT = 33'h1 << 8;
    localparam logic [32:0] MARIN = 33'h1 << 9,  ZIN = 33'h1 << 10,   PCIN = 33'h1 << 11;
    localparam logic [32:0] MDRIN = 33'h1 << 12, IRIN = 33'h1 << 13,  YIN = 33'h1 << 14;
    localparam logic [32:0] HIIN = 33'h1 << 15,  LOIN = 33'h1 << 16,  OUTPIN = 33'h1 << 17;
    localparam logic [32:0] CONIN = 33'h1 << 18, RIN = 33'h1 << 19,   GRA = 33'h1 << 20;
    localparam logic [32:0] GRB = 33'h1 << 21,   GRC = 33'h1 << 22,   ROUT = 33'h1 << 23;
    localparam logic [32:0] INCPC = 33'h1 << 24, READ = 33'h1 << 25,  WRITE = 33'h1 << 26;
    localparam logic [32:0] RUN = 33'h1 << 32;
    localparam logic [32:0] F0 = RUN | PCOUT | MARIN | INCPC | ZIN;
    localparam logic [32:0] F1 = RUN | ZLOW | PCIN | READ | MDRIN;
    localparam logic [32:0] F2 = RUN | MDROUT | IRIN;

    function automatic logic [32:0] alu(input logic [4:0] a);
        return {1'b0, a, 27'b0};
    endfunction

    logic [32:0] exp_q[$];
    string       tag_q[$];
    int          checks = 0;
    int          errors = 0;

    task automatic check_now();
        logic [32:0] obs, e;
        string t;
        obs = {bus.Run, bus.alu_op, bus.Write, bus.Read, bus.IncPC, bus.Rout, bus.Grc, bus.Grb,
               bus.Gra, bus.Rin, bus.CONin, bus.OutPortin, bus.LOin, bus.HIin, bus.Yin, bus.IRin,
               bus.MDRin, bus.PCin, bus.Zin, bus.MARin, bus.BAout, bus.Cout, bus.InPortout,
               bus.LOout, bus.HIout, bus.MDRout, bus.Zlowout, bus.Zhighout, bus.PCout};
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        checks++;
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", t, obs, e);
        end
        $display("t=%0t %s observed=%h expected=%h", $time, t, obs, e);
    endtask

    task automatic expect_now(input logic [32:0] e, input string tag);
        exp_q.push_back(e);
        tag_q.push_back(tag);
        check_now();
    endtask

    task automatic expect_step(input logic [32:0] e, input string tag);
        exp_q.push_back(e);
        tag_q.push_back(tag);
        @(posedge Clock);
        @(negedge Clock);
        check_now();
    endtask

    task automatic fetch(input string name);
        expect_step(F0, {name, "_t0"});
        expect_step(F1, {name, "_t1"});
        expect_step(F2, {name, "_t2"});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.IR = 32'h0; bus.CON_FF = 1'b0; bus.Stop = 1'b0;
        repeat (2) @(negedge Clock);
        expect_now(33'h0, "reset_outputs");

        // andi R2,R1,26; IR is scrambled after T2 to show the opcode is latched
        bus.IR = 32'h6108001A; Clear = 1'b1;
        fetch("andi");
        expect_step(RUN | GRB | ROUT | YIN, "andi_t3");
        bus.IR = 32'h0;
        expect_step(RUN | COUT | ZIN | alu(5'b01100), "andi_t4");
        expect_step(RUN | ZLOW | GRA | RIN, "andi_t5");

        bus.IR = 32'h00800014;
        fetch("ld");
        expect_step(RUN | GRB | BAOUT | YIN, "ld_t3");
        expect_step(RUN | COUT | ZIN | alu(5'b00011), "ld_t4");
        expect_step(RUN | ZLOW | MARIN, "ld_t5");
        expect_step(RUN | READ | MDRIN, "ld_t6");
        expect_step(RUN | MDROUT | GRA | RIN, "ld_t7");

        bus.IR = 32'h90000000; bus.CON_FF = 1'b1;
        fetch("br_taken");
        expect_step(RUN | GRA | ROUT | CONIN, "br_taken_t3");
        expect_step(RUN | PCOUT | YIN, "br_taken_t4");
        expect_step(RUN | COUT | ZIN | alu(5'b00011), "br_taken_t5");
        expect_step(RUN | ZLOW | PCIN, "br_taken_t6");

        bus.CON_FF = 1'b0;
        fetch("br_not");
        expect_step(RUN | GRA | ROUT | CONIN, "br_not_t3");
        expect_step(RUN | PCOUT | YIN, "br_not_t4");
        expect_step(RUN | COUT | ZIN | alu(5'b00011), "br_not_t5");
        expect_step(RUN, "br_not_t6");

        bus.IR = 32'h18000000;
        fetch("add");
        expect_step(RUN | GRB | ROUT | YIN, "add_t3");
        expect_step(RUN | GRC | ROUT | ZIN | alu(5'b00011), "add_t4");
        expect_step(RUN | ZLOW | GRA | RIN, "add_t5");

        bus.IR = 32'h88000000;
        fetch("not");
        expect_step(RUN | GRB | ROUT | ZIN | alu(5'b10001), "not_t3");
        expect_step(RUN | ZLOW | GRA | RIN, "not_t4");

        bus.IR = 32'hA0000000;
        fetch("jal");
        expect_step(RUN | PCOUT | GRB | RIN, "jal_t3");
        expect_step(RUN | GRA | ROUT | PCIN, "jal_t4");

        bus.IR = 32'hF8000000;
        fetch("undef");
        expect_step(F0, "undef_back_to_t0");
        bus.IR = 32'hD0000000;
        expect_step(F1, "halt_t1");
        expect_step(F2, "halt_t2");
        expect_step(33'h0, "halt_state_a");
        expect_step(33'h0, "halt_state_b");

        Clear = 1'b0;
        @(negedge Clock);
        bus.IR = 32'h70000000; Clear = 1'b1;
        fetch("mul");
        expect_step(RUN | GRA | ROUT | YIN, "mul_t3");
        expect_step(RUN | GRB | ROUT | ZIN | alu(5'b01110), "mul_t4");
        expect_step(RUN | ZLOW | LOIN, "mul_t5");
        bus.Stop = 1'b1;
        expect_step(RUN | ZHIGH | HIIN, "mul_t6_stop_ignored_midway");
        for (int i = 0; i < 10; i++) expect_step(33'h0, $sformatf("mul_halt_%0d", i));
        bus.Stop = 1'b0;

        Clear = 1'b0;
        @(negedge Clock);
        bus.IR = 32'h10000000; Clear = 1'b1;
        fetch("st");
        expect_step(RUN | GRB | BAOUT | YIN, "st_t3");
        expect_step(RUN | COUT | ZIN | alu(5'b00011), "st_t4");
        #2 Clear = 1'b0;
        #1 expect_now(33'h0, "st_async_clear");
        @(negedge Clock);
        expect_now(33'h0, "st_reset_held");
        bus.IR = 32'hC8000000; Clear = 1'b1;
        fetch("nop_after_clear");
        expect_step(F0, "nop_back_to_t0");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
